// File: rtl/acl_pkg.sv
// Shared constants, state encodings and the X-sample to tilt conversion
// for the ADXL362 SPI reader.
package acl_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_CFG,
    ST_IDLE,
    ST_READ,
    ST_UPDATE
  } acl_state_e;

  typedef enum logic [2:0] {
    EN_IDLE,
    EN_SETUP,
    EN_HIGH,
    EN_LOW,
    EN_HOLD,
    EN_GAP
  } eng_state_e;

  // x12 is the raw two's-complement sample; result is clamped to 0..1023.
  function automatic logic [9:0] x_to_tilt(input logic [11:0] x12, input int shift,
                                           input int center);
    logic signed [12:0] xs;
    logic signed [12:0] s;
    xs = signed'({x12[11], x12});
    xs = xs >>> shift;
    s  = xs + 13'(center);
    if (s[12]) begin
      return 10'd0;
    end else if (s > 13'sd1023) begin
      return 10'd1023;
    end else begin
      return s[9:0];
    end
  endfunction

endpackage

// File: rtl/acl_spi_byte_engine.sv
// Mode-0 SPI byte engine: frames 1..4 bytes under one cs_n assertion and
// enforces the cs_n setup/hold and inter-transaction gap.
module acl_spi_byte_engine
  import acl_pkg::*;
#(
  parameter int HALF = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  nbytes,
  input  logic [7:0]  tx_byte,
  output logic [1:0]  req_idx,
  output logic [15:0] rx_data,
  output logic        done,
  output logic        ready,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n
);

  localparam int CW = $clog2(2 * HALF + 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * HALF - 1);

  eng_state_e  st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  nb_q, nb_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;

  logic half_end, gap_end, last_byte;

  assign half_end  = (cnt_q == HALF_END);
  assign gap_end   = (cnt_q == GAP_END);
  assign last_byte = ({1'b0, idx_q} == (nb_q - 3'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= EN_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      idx_q  <= '0;
      nb_q   <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      idx_q  <= idx_d;
      nb_q   <= nb_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      sclk_q <= sclk_d;
      cs_n_q <= cs_n_d;
      mosi_q <= mosi_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      EN_IDLE:           if (start) st_d = EN_SETUP;
      EN_SETUP, EN_LOW:  if (half_end) st_d = EN_HIGH;
      EN_HIGH:           if (half_end) st_d = (bit_q == 3'd7 && last_byte) ? EN_HOLD : EN_LOW;
      EN_HOLD:           if (half_end) st_d = EN_GAP;
      EN_GAP:            if (gap_end) st_d = EN_IDLE;
      default:           st_d = EN_IDLE;
    endcase
  end

  // Rising edge samples MISO; falling edge presents the next MOSI bit.
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    idx_d  = idx_q;
    nb_d   = nb_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    sclk_d = sclk_q;
    cs_n_d = cs_n_q;
    mosi_d = mosi_q;
    done   = 1'b0;
    case (st_q)
      EN_IDLE: begin
        cnt_d = '0;
        if (start) begin
          cs_n_d = 1'b0;
          sh_d   = tx_byte;
          mosi_d = tx_byte[7];
          bit_d  = '0;
          idx_d  = '0;
          nb_d   = nbytes;
          rx_d   = '0;
        end
      end
      EN_SETUP, EN_LOW: begin
        cnt_d = cnt_q + CW'(1);
        if (half_end) begin
          cnt_d  = '0;
          sclk_d = 1'b1;
          rx_d   = {rx_q[14:0], spi_miso};
        end
      end
      EN_HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (half_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            if (last_byte) begin
              mosi_d = 1'b0;
            end else begin
              idx_d  = idx_q + 2'd1;
              sh_d   = tx_byte;
              mosi_d = tx_byte[7];
              bit_d  = '0;
            end
          end else begin
            bit_d  = bit_q + 3'd1;
            sh_d   = {sh_q[6:0], 1'b0};
            mosi_d = sh_q[6];
          end
        end
      end
      EN_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (half_end) begin
          cnt_d  = '0;
          cs_n_d = 1'b1;
          done   = 1'b1;
        end
      end
      EN_GAP: begin
        cnt_d = gap_end ? '0 : cnt_q + CW'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  assign req_idx  = (st_q == EN_IDLE) ? 2'd0 : idx_q + 2'd1;
  assign rx_data  = rx_q;
  assign ready    = (st_q == EN_IDLE);
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/acl_spi_reader.sv
// ADXL362 reader: powers the sensor into measurement mode, then polls XDATA
// at a fixed rate and publishes a clamped 10-bit tilt value.
module acl_spi_reader
  import acl_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int SCLK_HZ       = 1_000_000,
  parameter int BOOT_CYCLES   = 500_000,
  parameter int SAMPLE_CYCLES = 1_000_000,
  parameter int CENTER        = 314,
  parameter int SHIFT         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic [9:0] acl_out,
  output logic       acl_valid,
  output logic       init_done
);

  localparam int HALF = CLK_HZ / (2 * SCLK_HZ);
  localparam int BW   = $clog2(BOOT_CYCLES + 1);
  localparam int TW   = $clog2(SAMPLE_CYCLES + 1);

  acl_state_e  state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        pend_q, pend_d;
  logic        init_done_q, init_done_d;
  logic [9:0]  acl_out_q, acl_out_d;

  logic        eng_start, eng_done, eng_ready;
  logic [2:0]  eng_nbytes;
  logic [7:0]  eng_tx;
  logic [1:0]  eng_req_idx;
  logic [15:0] eng_rx;
  logic        unused_rx_hi;

  logic boot_end, wrap, launch, cfg_sel;

  assign boot_end = (boot_q == BW'(BOOT_CYCLES - 1));
  assign wrap     = init_done_q && (timer_q == TW'(SAMPLE_CYCLES - 1));
  // A wrap that lands while a read is still running is remembered in pend_q.
  assign launch   = (state_q == ST_IDLE) && (wrap || pend_q) && eng_ready;
  assign cfg_sel  = (state_q == ST_BOOT) || (state_q == ST_CFG);
  assign unused_rx_hi = ^eng_rx[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      boot_q      <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      init_done_q <= 1'b0;
      acl_out_q   <= 10'(CENTER);
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      init_done_q <= init_done_d;
      acl_out_q   <= acl_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   if (boot_end) state_d = ST_CFG;
      ST_CFG:    if (eng_done) state_d = ST_IDLE;
      ST_IDLE:   if (launch) state_d = ST_READ;
      ST_READ:   if (eng_done) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    eng_start  = ((state_q == ST_BOOT) && boot_end) || launch;
    eng_nbytes = (state_q == ST_BOOT) ? 3'd3 : 3'd4;
    acl_valid  = (state_q == ST_UPDATE);
  end

  always_comb begin
    boot_d      = (state_q == ST_BOOT && !boot_end) ? boot_q + BW'(1) : boot_q;
    init_done_d = init_done_q | ((state_q == ST_CFG) && eng_done);
    pend_d      = launch ? 1'b0 : (pend_q | wrap);
    if ((state_q == ST_CFG) && eng_done) begin
      timer_d = '0;
    end else if (init_done_q) begin
      timer_d = wrap ? '0 : timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
    // rx holds {XDATA_L, XDATA_H} once the last read byte has shifted in.
    if ((state_q == ST_READ) && eng_done) begin
      acl_out_d = x_to_tilt({eng_rx[3:0], eng_rx[15:8]}, SHIFT, CENTER);
    end else begin
      acl_out_d = acl_out_q;
    end
  end

  always_comb begin
    case (eng_req_idx)
      2'd0:    eng_tx = cfg_sel ? CMD_WRITE : CMD_READ;
      2'd1:    eng_tx = cfg_sel ? REG_POWER_CTL : REG_XDATA_L;
      2'd2:    eng_tx = cfg_sel ? PWR_MEASURE : 8'h00;
      default: eng_tx = 8'h00;
    endcase
  end

  acl_spi_byte_engine #(
    .HALF(HALF)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .nbytes   (eng_nbytes),
    .tx_byte  (eng_tx),
    .req_idx  (eng_req_idx),
    .rx_data  (eng_rx),
    .done     (eng_done),
    .ready    (eng_ready),
    .spi_miso (spi_miso),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n)
  );

  assign acl_out   = acl_out_q;
  assign init_done = init_done_q;

endmodule
